led_pattern_sequencer: RTL and testbench

//  Owns the on-board active-low RGB LED. Runs a 32-slot time-sliced mix between adjacent

---
 rtl/led_pattern_sequencer_pkg.sv | 39 +++
 rtl/led_pattern_sequencer_button_debouncer.sv | 47 ++++
 rtl/led_pattern_sequencer.sv | 162 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared colour codes, display modes and the rainbow base-colour lookup.
// Colours are active-low {R,B,G}: a 0 bit lights that channel.
package led_pkg;

  localparam logic [2:0] COLOR_RED     = 3'b011;
  localparam logic [2:0] COLOR_YELLOW  = 3'b010;
  localparam logic [2:0] COLOR_GREEN   = 3'b110;
  localparam logic [2:0] COLOR_CYAN    = 3'b100;
  localparam logic [2:0] COLOR_BLUE    = 3'b101;
  localparam logic [2:0] COLOR_MAGENTA = 3'b001;
  localparam logic [2:0] COLOR_OFF     = 3'b111;

  localparam logic [2:0] LAST_SEG = 3'd5;

  typedef enum logic [1:0] {
    MODE_RAINBOW = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  // Indices 6 and 7 fold back onto the start of the wheel so seg+1 never needs a wrap.
  function automatic logic [2:0] base_color(input logic [2:0] seg);
    logic [2:0] color;
    color = COLOR_RED;
    case (seg)
      3'd0:    color = COLOR_RED;
      3'd1:    color = COLOR_YELLOW;
      3'd2:    color = COLOR_GREEN;
      3'd3:    color = COLOR_CYAN;
      3'd4:    color = COLOR_BLUE;
      3'd5:    color = COLOR_MAGENTA;
      3'd6:    color = COLOR_RED;
      default: color = COLOR_YELLOW;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_button_debouncer.sv
// Raw active-low button -> 2-FF sync -> stable-level filter -> one-clk press pulse.
// Press pulse follows DEBOUNCE_TICKS+2 clk after the raw low level; no backpressure.
module button_debouncer #(
  parameter int DEBOUNCE_TICKS = 480_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any sample that agrees with the accepted level restarts the stability window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Active-low RGB LED driver: 32-slot time-sliced rainbow mix, blink/solid/off modes, two buttons.
// LED output registered one clk behind the slot counter; free-running, no backpressure.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int PWM_BITS       = 5,
  parameter int STEPS_PER_SEG  = 32,
  parameter int STEP_TICKS     = 1_250_000,
  parameter int BLINK_TICKS    = 12_000_000,
  parameter int DEBOUNCE_TICKS = 480_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_pause_n,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       frame_strobe
);

  localparam int STEP_W  = (STEP_TICKS > 1)  ? $clog2(STEP_TICKS)  : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PWM_BITS-1:0] SLOT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] FRAC_MAX  = PWM_BITS'(STEPS_PER_SEG - 1);
  localparam logic [PWM_BITS:0]   SEG_STEPS = STEPS_PER_SEG[PWM_BITS:0];
  localparam logic [STEP_W-1:0]   STEP_MAX  = STEP_W'(STEP_TICKS - 1);
  localparam logic [BLINK_W-1:0]  BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

  logic                r_paused;
  mode_e               r_mode;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_on;

  logic [PWM_BITS-1:0] r_slot;
  logic [2:0]          r_led;

  logic [2:0]          r_seg;
  logic [PWM_BITS-1:0] r_frac;
  logic [STEP_W-1:0]   r_step_cnt;
  logic                r_step_pend;

  logic                w_mode_press;
  logic                w_pause_press;
  logic                w_frame_end;
  logic                w_hue_run;
  logic                w_step_tc;
  logic                w_step_apply;
  logic                w_blink_run;
  logic                w_blink_tc;
  logic [PWM_BITS:0]   w_thresh;
  logic [2:0]          w_mix;

  button_debouncer #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_mode_db (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (btn_mode_n),
    .o_press (w_mode_press)
  );

  button_debouncer #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_pause_db (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (btn_pause_n),
    .o_press (w_pause_press)
  );

  assign w_frame_end  = (r_slot == SLOT_MAX);
  assign w_hue_run    = (r_mode == MODE_RAINBOW) && !r_paused;
  assign w_step_tc    = w_hue_run && (r_step_cnt == STEP_MAX);
  // A pending step waits for the frame boundary and is held while the hue is frozen.
  assign w_step_apply = w_hue_run && w_frame_end && r_step_pend;
  assign w_blink_run  = (r_mode == MODE_BLINK) && !r_paused;
  assign w_blink_tc   = w_blink_run && (r_blink_cnt == BLINK_MAX);

  assign w_thresh = SEG_STEPS - {1'b0, r_frac};
  assign w_mix    = ({1'b0, r_slot} < w_thresh) ? base_color(r_seg) : base_color(r_seg + 3'd1);

  // Mode sequencing, pause toggle and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_RAINBOW;
      r_paused    <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      if (w_pause_press) begin
        r_paused <= ~r_paused;
      end
      if (w_mode_press) begin
        case (r_mode)
          MODE_RAINBOW: r_mode <= MODE_BLINK;
          MODE_BLINK:   r_mode <= MODE_SOLID;
          MODE_SOLID:   r_mode <= MODE_OFF;
          default:      r_mode <= MODE_RAINBOW;
        endcase
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (w_blink_tc) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else if (w_blink_run) begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Hue scheduler: step timer, single-deep pending flag, seg/frac position on the wheel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt  <= '0;
      r_step_pend <= 1'b0;
      r_seg       <= 3'd0;
      r_frac      <= '0;
    end else begin
      if (w_step_tc) begin
        r_step_cnt <= '0;
      end else if (w_hue_run) begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end

      if (w_step_tc) begin
        r_step_pend <= 1'b1;
      end else if (w_step_apply) begin
        r_step_pend <= 1'b0;
      end

      if (w_step_apply) begin
        if (r_frac == FRAC_MAX) begin
          r_frac <= '0;
          r_seg  <= (r_seg == LAST_SEG) ? 3'd0 : r_seg + 3'd1;
        end else begin
          r_frac <= r_frac + 1'b1;
        end
      end
    end
  end

  // Slot counter and registered LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_led  <= COLOR_OFF;
    end else begin
      r_slot <= r_slot + 1'b1;
      case (r_mode)
        MODE_RAINBOW, MODE_SOLID: r_led <= w_mix;
        MODE_BLINK:               r_led <= r_blink_on ? w_mix : COLOR_OFF;
        default:                  r_led <= COLOR_OFF;
      endcase
    end
  end

  assign led          = r_led;
  assign mode         = r_mode;
  assign frame_strobe = w_frame_end;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised button stimulus against a hue-index reference model, plus literal frame pins.
module tb_led_pattern_sequencer;

  localparam int STEP  = 64;
  localparam int BLINK = 100;
  localparam int DEB   = 8;
  localparam int FR    = 32;
  localparam int HUES  = 6 * FR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode_n = 1'b1;
  logic       btn_pause_n = 1'b1;
  logic [2:0] led;
  logic [1:0] mode;
  logic       frame_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  led_pattern_sequencer #(
    .PWM_BITS       (5),
    .STEPS_PER_SEG  (32),
    .STEP_TICKS     (STEP),
    .BLINK_TICKS    (BLINK),
    .DEBOUNCE_TICKS (DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode_n   (btn_mode_n),
    .btn_pause_n  (btn_pause_n),
    .led          (led),
    .mode         (mode),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  logic [2:0] wheel [6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};

  // Reference state: hue is a single index 0..191 around the colour wheel.
  int         m_tick;
  int         m_hue;
  int         m_step_el;
  bit         m_pend;
  int         m_mode;
  bit         m_paused;
  bit         m_blink_on;
  int         m_blink_el;
  logic [2:0] m_led;
  int         run_lo [2];
  int         run_hi [2];
  int         dly [2];
  bit         lvl [2];
  bit         raw [2];
  bit         prs [2];

  function automatic logic [2:0] mix_color(input int slot, input int hue);
    int seg;
    int frac;
    seg  = hue / FR;
    frac = hue % FR;
    if (slot < FR - frac) return wheel[seg];
    return wheel[(seg + 1) % 6];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tick = 0; m_hue = 0; m_step_el = 0; m_pend = 0;
    m_mode = 0; m_paused = 0; m_blink_on = 1; m_blink_el = 0;
    m_led = 3'b111;
    for (int i = 0; i < 2; i++) begin
      run_lo[i] = 0; run_hi[i] = 0; dly[i] = 0; lvl[i] = 1;
    end
  endtask

  task automatic model_step();
    int slot;
    bit fs;
    bit tc;
    bit apply;
    slot = m_tick % FR;
    fs   = (slot == FR - 1);
    case (m_mode)
      0, 2:    m_led = mix_color(slot, m_hue);
      1:       m_led = m_blink_on ? mix_color(slot, m_hue) : 3'b111;
      default: m_led = 3'b111;
    endcase
    if (m_mode == 0 && !m_paused) begin
      tc        = (m_step_el == STEP - 1);
      apply     = fs && m_pend;
      m_step_el = (m_step_el + 1) % STEP;
      if (apply) begin
        m_hue  = (m_hue + 1) % HUES;
        m_pend = 0;
      end
      if (tc) m_pend = 1;
    end
    raw[0] = btn_mode_n;
    raw[1] = btn_pause_n;
    // A press lands 3 clk after the DEB-th consecutive low sample.
    for (int i = 0; i < 2; i++) begin
      prs[i] = 0;
      if (dly[i] > 0) begin
        dly[i]--;
        prs[i] = (dly[i] == 0);
      end
      if (raw[i]) begin run_hi[i]++; run_lo[i] = 0; end
      else        begin run_lo[i]++; run_hi[i] = 0; end
      if (lvl[i] && run_lo[i] == DEB) begin lvl[i] = 0; dly[i] = 3; end
      if (!lvl[i] && run_hi[i] == DEB) lvl[i] = 1;
    end
    if (prs[0]) begin
      m_mode = (m_mode + 1) % 4;
      m_blink_el = 0;
      m_blink_on = 1;
    end else if (m_mode == 1 && !m_paused) begin
      if (m_blink_el == BLINK - 1) begin
        m_blink_el = 0;
        m_blink_on = !m_blink_on;
      end else begin
        m_blink_el++;
      end
    end
    if (prs[1]) m_paused = !m_paused;
    m_tick++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("led", 32'(led), 32'(m_led));
        check("mode", 32'(mode), 32'(m_mode));
        check("frame_strobe", 32'(frame_strobe), 32'((m_tick % FR) == FR - 1));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit m, input bit p, input int len);
    @(negedge clk);
    if (m) btn_mode_n = 1'b0;
    if (p) btn_pause_n = 1'b0;
    repeat (len) @(negedge clk);
    btn_mode_n  = 1'b1;
    btn_pause_n = 1'b1;
    idle(2 * DEB + 10);
  endtask

  task automatic count_dark(input int n, output int dark);
    dark = 0;
    repeat (n) begin
      @(negedge clk);
      if (led == 3'b111) dark++;
    end
  endtask

  task automatic pin_frame(input string name, input int start_tick, input int yellow_from, input logic [2:0] a, input logic [2:0] b);
    while (m_tick < start_tick) @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      check(name, 32'(led), (i < yellow_from) ? 32'(a) : 32'(b));
    end
  endtask

  initial begin
    int dark;
    int kind;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(45);
    rst = 1'b1;
    #1;
    check("reset_led", 32'(led), 32'h7);
    check("reset_mode", 32'(mode), 32'h0);
    check("reset_fs", 32'(frame_strobe), 32'h0);
    idle(2);
    rst = 1'b0;

    pin_frame("first_frame", 0, FR, 3'b011, 3'b011);
    pin_frame("frac4_frame", 288, 28, 3'b011, 3'b010);
    pin_frame("step32_frame", 2080, FR, 3'b010, 3'b010);
    pin_frame("wrap192_frame", 12320, FR, 3'b011, 3'b011);

    push(1, 0, 5);
    check("glitch_mode", 32'(mode), 32'h0);
    push(1, 0, 20);
    check("press1_mode", 32'(mode), 32'h1);
    push(1, 0, 20);
    check("press2_mode", 32'(mode), 32'h2);
    push(1, 0, 20);
    check("press3_mode", 32'(mode), 32'h3);
    push(1, 0, 20);
    check("press4_mode", 32'(mode), 32'h0);

    push(1, 0, 20);
    count_dark(350, dark);
    check("blink_dark_seen", 32'(dark > 0), 32'h1);
    push(0, 1, 20);
    idle(300);
    push(0, 1, 20);
    idle(200);
    push(1, 0, 20);
    push(1, 0, 20);
    push(1, 0, 20);
    check("back_rainbow", 32'(mode), 32'h0);

    push(1, 1, 20);
    check("simul_mode", 32'(mode), 32'h1);
    count_dark(300, dark);
    check("simul_blink_held", 32'(dark), 32'h0);
    push(0, 1, 20);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: push(1, 0, $urandom_range(DEB, DEB + 30));
        1: push(0, 1, $urandom_range(DEB, DEB + 30));
        2: push(1, 1, $urandom_range(DEB, DEB + 30));
        3: push($urandom_range(0, 1) == 1, 1'b0, $urandom_range(1, DEB - 1));
        default: idle($urandom_range(50, 400));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
